// File: rtl/floor_input_comparator.sv
// floor_input_comparator
//
// Purpose:
//   Decides where a newly requested floor goes in the elevator request memory.
//   A request that lies strictly between the car's current floor and the floor
//   at the memory head, in the direction of travel, is inserted at the head
//   (beginEndMemory_Flag = 1). Every other request is appended at the tail
//   (beginEndMemory_Flag = 0). An empty memory always takes the request at the
//   head. The decision is registered one cycle after req_valid is sampled, and
//   it holds until the next sampled request.
//
// Optional feature:
//   FLOOR_INPUT_COMPARATOR_DUP_EN - when defined, a request equal to the current
//   floor or to the head floor is flagged as a duplicate (dup_Flag = 1). Its
//   decision is forced to 0, and this check takes priority over mem_empty.
//   When undefined, dup_Flag is tied to 0 but the port is kept.
//
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset
//   req_valid            in   one-cycle strobe: sample a new request
//   floor_destiny_Input  in   [FLOOR_W] requested destination floor
//   pos0Mem              in   [FLOOR_W] floor at head of request memory
//   actualFloor          in   [FLOOR_W] floor the car is currently at
//   down_up_Flag         in   travel direction, 1 = up, 0 = down
//   mem_empty            in   request memory holds no entries
//   beginEndMemory_Flag  out  registered decision, 1 = head, 0 = tail
//   result_valid         out  one-cycle pulse after each sampled request
//   dup_Flag             out  registered duplicate indication

module floor_input_comparator #(
  parameter int FLOOR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] floor_destiny_Input,
  input  logic [FLOOR_W-1:0] pos0Mem,
  input  logic [FLOOR_W-1:0] actualFloor,
  input  logic               down_up_Flag,
  input  logic               mem_empty,
  output logic               beginEndMemory_Flag,
  output logic               result_valid,
  output logic               dup_Flag
);

  logic on_the_way;
  logic next_decision;

  // The request is "on the way" when it lies strictly between the current floor
  // and the head floor, in the direction of travel. A request in the opposite
  // direction, or past the head floor, fails both tests.
  always_comb begin
    on_the_way = 1'b0;
    if (down_up_Flag)
      on_the_way = (actualFloor < floor_destiny_Input) && (floor_destiny_Input < pos0Mem);
    else
      on_the_way = (pos0Mem < floor_destiny_Input) && (floor_destiny_Input < actualFloor);
  end

`ifdef FLOOR_INPUT_COMPARATOR_DUP_EN
  logic is_dup;

  // A duplicate is never inserted at the head, even into an empty memory.
  always_comb begin
    is_dup        = (floor_destiny_Input == actualFloor) || (floor_destiny_Input == pos0Mem);
    next_decision = 1'b0;
    if (is_dup)
      next_decision = 1'b0;
    else if (mem_empty)
      next_decision = 1'b1;
    else
      next_decision = on_the_way;
  end

  // The duplicate flag changes only on a sampled request, so it stays in step
  // with the decision register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dup_Flag <= 1'b0;
    else if (req_valid)
      dup_Flag <= is_dup;
  end
`else
  always_comb begin
    next_decision = 1'b0;
    if (mem_empty)
      next_decision = 1'b1;
    else
      next_decision = on_the_way;
  end

  assign dup_Flag = 1'b0;
`endif

  // The decision holds between requests. result_valid re-evaluates on every
  // edge, so back-to-back requests each produce their own pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beginEndMemory_Flag <= 1'b0;
      result_valid        <= 1'b0;
    end else begin
      result_valid <= req_valid;
      if (req_valid)
        beginEndMemory_Flag <= next_decision;
    end
  end

endmodule

// File: tb/tb_floor_input_comparator.sv
// Testbench for floor_input_comparator.
// Drives directed cases and random requests. Every output is compared against a
// behavioural model that works from signed floor distances.

module tb_floor_input_comparator;

  localparam int FW = 2;
  localparam int MAXF = (1 << FW) - 1;

`ifdef FLOOR_INPUT_COMPARATOR_DUP_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [FW-1:0] floor_destiny_Input;
  logic [FW-1:0] pos0Mem;
  logic [FW-1:0] actualFloor;
  logic          down_up_Flag;
  logic          mem_empty;
  logic          beginEndMemory_Flag;
  logic          result_valid;
  logic          dup_Flag;

  int check_count;
  int error_count;

  logic exp_dec;
  logic exp_dup;
  logic exp_rv;

  floor_input_comparator #(.FLOOR_W(FW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .floor_destiny_Input (floor_destiny_Input),
    .pos0Mem             (pos0Mem),
    .actualFloor         (actualFloor),
    .down_up_Flag        (down_up_Flag),
    .mem_empty           (mem_empty),
    .beginEndMemory_Flag (beginEndMemory_Flag),
    .result_valid        (result_valid),
    .dup_Flag            (dup_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The request is on the way when the signed distance from the car to the
  // request, and the signed distance from the request to the head floor, are
  // both positive in the direction of travel.
  function automatic bit modelOnWay(int dest, int pos0, int act, bit up);
    int s;
    s = up ? 1 : -1;
    return ((dest - act) * s > 0) && ((pos0 - dest) * s > 0);
  endfunction

  function automatic bit modelDup(int dest, int pos0, int act);
    return DUP_EN && (dest == act || dest == pos0);
  endfunction

  function automatic bit modelDecision(int dest, int pos0, int act, bit up, bit empty);
    if (modelDup(dest, pos0, act)) return 1'b0;
    if (empty) return 1'b1;
    return modelOnWay(dest, pos0, act, up);
  endfunction

  task automatic checkOutput(input string tag, input logic got, input logic expv);
    check_count++;
    if (got !== expv) begin
      error_count++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rv"}, result_valid, exp_rv);
    checkOutput({tag, ".dec"}, beginEndMemory_Flag, exp_dec);
    checkOutput({tag, ".dup"}, dup_Flag, exp_dup);
  endtask

  // Drive one cycle of inputs on the falling edge, update the model, and check
  // the outputs just after the next rising edge.
  task automatic applyStimulus(input string tag, input bit v, input int dest, input int pos0,
                               input int act, input bit up, input bit empty);
    @(negedge clk);
    req_valid           = v;
    floor_destiny_Input = FW'(dest);
    pos0Mem             = FW'(pos0);
    actualFloor         = FW'(act);
    down_up_Flag        = up;
    mem_empty           = empty;
    exp_rv = v;
    if (v) begin
      exp_dec = modelDecision(dest, pos0, act, up, empty);
      exp_dup = modelDup(dest, pos0, act);
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    exp_dec = 1'b0;
    exp_dup = 1'b0;
    exp_rv  = 1'b0;
    // A request held during reset must be discarded.
    rst_n = 1'b0;
    req_valid = 1'b1;
    floor_destiny_Input = 2'd2;
    pos0Mem = 2'd3;
    actualFloor = 2'd1;
    down_up_Flag = 1'b1;
    mem_empty = 1'b1;
    #1;
    checkAll("reset0");
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_clk");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkAll("post_release");

    // Directed cases from the decision rules.
    applyStimulus("up_between",   1, 2, 3, 1, 1, 0);
    applyStimulus("idle",         0, 0, 0, 3, 0, 0);
    applyStimulus("up_beyond",    1, 3, 2, 1, 1, 0);
    applyStimulus("up_between2",  1, 2, 3, 0, 1, 0);
    applyStimulus("dn_between",   1, 1, 0, 3, 0, 0);
    applyStimulus("dn_opposite",  1, 3, 1, 2, 0, 0);
    applyStimulus("dn_beyond",    1, 0, 1, 2, 0, 0);
    applyStimulus("empty_any",    1, 0, 3, 1, 1, 1);
    applyStimulus("empty_eq_act", 1, 1, 3, 1, 1, 1);
    applyStimulus("eq_act",       1, 1, 3, 1, 1, 0);
    applyStimulus("eq_pos0",      1, 3, 3, 1, 1, 0);
    applyStimulus("hold",         0, 2, 3, 1, 1, 0);

    // Three back-to-back requests with differing decisions.
    applyStimulus("b2b_a", 1, 2, 3, 1, 1, 0);
    applyStimulus("b2b_b", 1, 0, 1, 2, 0, 0);
    applyStimulus("b2b_c", 1, 1, 0, 3, 0, 0);
    applyStimulus("b2b_end", 0, 1, 0, 3, 0, 0);

    // Reset asserted mid-cycle with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    floor_destiny_Input = 2'd2;
    pos0Mem = 2'd3;
    actualFloor = 2'd1;
    down_up_Flag = 1'b1;
    mem_empty = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_dec = 1'b0;
    exp_dup = 1'b0;
    exp_rv  = 1'b0;
    #1;
    checkAll("mid_reset");
    @(posedge clk);
    #1;
    checkAll("mid_reset_clk");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkAll("mid_release");
    applyStimulus("after_reset", 1, 2, 3, 1, 1, 0);

    // Random requests, with req_valid toggled at random.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, MAXF)), int'($urandom_range(0, MAXF)),
                    int'($urandom_range(0, MAXF)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/floor_input_comparator.md
FLOOR_INPUT_COMPARATOR -- requirements
Module: floor_input_comparator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 FLOOR_W SHALL be a parameter, default 2, giving the floor-number width in bits.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  high for one cycle to sample a new floor request.
REQ-006 floor_destiny_Input  input  FLOOR_W  requested destination floor.
REQ-007 pos0Mem  input  FLOOR_W  floor stored at position 0 (head) of the request memory.
REQ-008 actualFloor  input  FLOOR_W  floor the car is currently at.
REQ-009 down_up_Flag  input  1  travel direction: 1 = up, 0 = down.
REQ-010 mem_empty  input  1  high when the request memory holds no entries.
REQ-011 beginEndMemory_Flag  output  1  registered decision: 1 = insert request at memory head, 0 = append at tail.
REQ-012 result_valid  output  1  one-cycle pulse marking a new decision.
REQ-013 dup_Flag  output  1  registered: the request equals actualFloor or pos0Mem.

Function
REQ-014 All floor comparisons SHALL be unsigned, FLOOR_W bits wide.
REQ-015 Up case (down_up_Flag=1): the "on the way" term SHALL be 1 iff actualFloor < floor_destiny_Input < pos0Mem, using strict inequalities.
REQ-016 Down case (down_up_Flag=0): the "on the way" term SHALL be 1 iff pos0Mem < floor_destiny_Input < actualFloor, using strict inequalities.
REQ-017 Decision priority SHALL be, highest first:
  - duplicate (macro enabled): decision 0, dup 1;
  - mem_empty=1: decision 1;
  - otherwise: decision = "on the way" term.
REQ-018 A request opposite to the travel direction, or beyond pos0Mem, SHALL yield decision 0.
REQ-019 When req_valid=1 at a rising clk edge, the block SHALL register beginEndMemory_Flag and dup_Flag from the inputs sampled at that edge, giving 1-cycle latency.
REQ-020 result_valid SHALL be 1 in the cycle after a req_valid sample, and 0 otherwise.
REQ-021 While req_valid=0, beginEndMemory_Flag and dup_Flag SHALL hold their last values.
REQ-022 Back-to-back req_valid cycles SHALL each produce an independent decision and a result_valid pulse; no request is dropped.
REQ-023 Equal-floor boundaries SHALL follow REQ-017. Without the macro, destination == actualFloor or == pos0Mem fails the strict test and yields 0, unless mem_empty=1.

Reset
REQ-024 While rst_n=0, beginEndMemory_Flag, dup_Flag and result_valid SHALL all be 0, independent of clk.
REQ-025 A req_valid asserted while rst_n=0 SHALL be discarded and produce no result_valid after reset release.
REQ-026 The first sample SHALL occur at the first rising clk edge with rst_n=1.

Configuration
REQ-027 Macro FLOOR_INPUT_COMPARATOR_DUP_EN SHALL control duplicate detection.
  - Defined: duplicate detection per REQ-017.
  - Undefined: dup_Flag is tied to 0, the duplicate priority level is removed, and the port remains present.

Verification
REQ-028 up, actual=1, dest=2, pos0=3, empty=0 -> decision 1 after 1 cycle, result_valid pulse.
REQ-029 up, actual=1, dest=3, pos0=2 -> 0; up, actual=0, dest=2, pos0=3 -> 1.
REQ-030 down, actual=3, dest=1, pos0=0 -> 1; down, actual=2, dest=3, pos0=1 -> 0; down, actual=2, dest=0, pos0=1 -> 0.
REQ-031 mem_empty=1, up, actual=1, dest=0 -> 1. With the macro, dest=1 as well -> decision 0, dup 1; without the macro, dest=1 -> decision 1, dup 0.
REQ-032 rst_n pulled low mid-stream with req_valid held -> all outputs 0 immediately; after release, a new request gives a decision one cycle later.
REQ-033 req_valid high for 3 consecutive cycles with differing inputs -> 3 consecutive result_valid cycles with the matching decisions.
